// File: rtl/dclock_wrapper.sv
// dclock_wrapper: board top for the DClocking FPGA.
// UART command port (8E1) with echo, status LEDs and a dual-DAC pin set whose
// data buses carry the last valid received byte. SPI/I2C DAC control is parked.
module dclock_wrapper #(
    parameter int CLK_FREQ = 200_000_000,
    parameter int BAUD     = 57600,
    parameter int HB_DIV   = 100_000_000
) (
    input  logic        sys_clk_p,
    input  logic        sys_clk_n,
    input  logic        rst,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        led_1_o,
    output logic        led_2_o,
    output logic        led_3_o,
    output logic        led_4_o,
    output logic        panel_led_1_o,
    output logic        panel_led_2_o,
    output logic        dac_1_2_dci_p_ddr_o,
    output logic        dac_1_2_dci_n_ddr_o,
    output logic        dac_3_4_dci_p_ddr_o,
    output logic        dac_3_4_dci_n_ddr_o,
    output logic [13:0] dac_1_2_data_p_ddr_o,
    output logic [13:0] dac_1_2_data_n_ddr_o,
    output logic [13:0] dac_3_4_data_p_ddr_o,
    output logic [13:0] dac_3_4_data_n_ddr_o,
    input  logic        dac_1_2_dco_p_i,
    input  logic        dac_1_2_dco_n_i,
    input  logic        dac_3_4_dco_p_i,
    input  logic        dac_3_4_dco_n_i,
    output logic        dac_1_2_spi_ss_o,
    output logic        dac_3_4_spi_ss_o,
    output logic        dac_clk_spi_ss_o,
    output logic        dac_spi_sck_o,
    output logic        dac_spi_mosi_o,
    input  logic        dac_spi_miso_i,
    output logic        dac_eeprom_iic_scl_o,
    inout  wire         dac_eeprom_iic_sda_io
);

    // Bit period in clocks (truncated) and the counter widths derived from it.
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam int HBW     = $clog2(HB_DIV + 1);

    localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CYC / 2 - 1);
    localparam logic [HBW-1:0] HB_LAST   = HBW'(HB_DIV - 1);

    // ------------------------------------------------------------------
    // Clocking. The differential buffer is modelled by taking the p leg as
    // the fabric clock; the n leg only exists for the pad pair.
    // ------------------------------------------------------------------
    logic clk;
    assign clk = sys_clk_p;

    // Inputs that the board routes to us but that this design never reads.
    logic unused_in;
    assign unused_in = ^{sys_clk_n, dac_1_2_dco_p_i, dac_1_2_dco_n_i,
                         dac_3_4_dco_p_i, dac_3_4_dco_n_i, dac_spi_miso_i};

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    rx_state_t     rx_state_q, rx_state_d;
    logic          rxd_meta_q, rxd_sync_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_perr_q, rx_perr_d;     // parity verdict of the frame in flight
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_toggle_q, rx_toggle_d;
    logic          perr_flag_q, perr_flag_d;
    logic          ferr_flag_q, ferr_flag_d;
    logic          rx_busy;

    // Two-flop synchronizer for the asynchronous receive line (idle high).
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd_i;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // RX state register plus the datapath registers the FSM steers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_perr_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_toggle_q <= 1'b0;
            perr_flag_q <= 1'b0;
            ferr_flag_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_perr_q   <= rx_perr_d;
            rx_valid_q  <= rx_valid_d;
            rx_byte_q   <= rx_byte_d;
            rx_toggle_q <= rx_toggle_d;
            perr_flag_q <= perr_flag_d;
            ferr_flag_q <= ferr_flag_d;
        end
    end

    // RX next state: start qualified at half bit, then one mid-bit sample per bit period.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_perr_d   = rx_perr_q;
        rx_valid_d  = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_toggle_d = rx_toggle_q;
        perr_flag_d = perr_flag_q;
        ferr_flag_d = ferr_flag_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rxd_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A high line at mid start bit is a glitch: drop silently.
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = ^{rx_shift_q, rxd_sync_q};
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rxd_sync_q) begin
                        rx_state_d = RX_IDLE;
                        if (!rx_perr_q) begin
                            rx_valid_d  = 1'b1;
                            rx_byte_d   = rx_shift_q;
                            rx_toggle_d = ~rx_toggle_q;
                            perr_flag_d = 1'b0;
                            ferr_flag_d = 1'b0;
                        end else begin
                            perr_flag_d = 1'b1;
                        end
                    end else begin
                        // Break or misframed byte: wait for the line to return high.
                        ferr_flag_d = 1'b1;
                        if (rx_perr_q) perr_flag_d = 1'b1;
                        rx_state_d  = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_sync_q) rx_state_d = RX_IDLE;
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX outputs decoded from the current state.
    always_comb begin
        rx_busy = (rx_state_q != RX_IDLE);
    end

    // ------------------------------------------------------------------
    // TX path with a one-entry holding register.
    // Handshake: rx_valid_q is a one-cycle pulse with no back-pressure. The
    // holding register accepts it when empty, or when TX takes the held byte
    // in that same cycle; otherwise the new byte is dropped.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_par_q, tx_par_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          txd_q;
    logic          tx_take;
    logic          hold_accept;
    logic          tx_line;
    logic          tx_busy;

    // TX state register, holding register and the retimed line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= tx_line;
        end
    end

    // TX next state: serialise one bit per period and reload straight from the
    // holding register at the end of the stop bit so a waiting byte never stalls.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_take    = (tx_state_q == TX_IDLE) ||
                     ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST));
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_PARITY;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase
        if (tx_take && hold_full_q) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = hold_q;
            tx_par_d   = ^hold_q;
        end
    end

    // Holding register: accept when empty or being emptied this cycle.
    always_comb begin
        hold_accept = rx_valid_q && (!hold_full_q || tx_take);
        hold_d      = hold_accept ? rx_byte_q : hold_q;
        if (hold_accept)  hold_full_d = 1'b1;
        else if (tx_take) hold_full_d = 1'b0;
        else              hold_full_d = hold_full_q;
    end

    // TX outputs decoded from the current state.
    always_comb begin
        tx_busy = (tx_state_q != TX_IDLE);
        case (tx_state_q)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift_q[0];
            TX_PARITY: tx_line = tx_par_q;
            default:   tx_line = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [HBW-1:0] hb_cnt_q;
    logic           hb_led_q;

    // Free-running divider; the LED flips each time the divider wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb_led_q <= 1'b0;
        end else if (hb_cnt_q == HB_LAST) begin
            hb_cnt_q <= '0;
            hb_led_q <= ~hb_led_q;
        end else begin
            hb_cnt_q <= hb_cnt_q + HBW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Board outputs
    // ------------------------------------------------------------------
    assign uart_txd_o    = txd_q;
    assign led_1_o       = hb_led_q;
    assign led_2_o       = rx_toggle_q;
    assign led_3_o       = perr_flag_q;
    assign led_4_o       = ferr_flag_q;
    assign panel_led_1_o = rx_busy;
    assign panel_led_2_o = tx_busy;

    // DAC data clocks follow the system clock; the n leg is its complement.
    assign dac_1_2_dci_p_ddr_o = clk;
    assign dac_1_2_dci_n_ddr_o = ~clk;
    assign dac_3_4_dci_p_ddr_o = clk;
    assign dac_3_4_dci_n_ddr_o = ~clk;

    // Both DAC buses show the last valid byte in the top bits.
    logic [13:0] dac_word;
    assign dac_word             = {rx_byte_q, 6'b000000};
    assign dac_1_2_data_p_ddr_o = dac_word;
    assign dac_1_2_data_n_ddr_o = ~dac_word;
    assign dac_3_4_data_p_ddr_o = dac_word;
    assign dac_3_4_data_n_ddr_o = ~dac_word;

    // DAC control buses parked idle.
    assign dac_1_2_spi_ss_o      = 1'b1;
    assign dac_3_4_spi_ss_o      = 1'b1;
    assign dac_clk_spi_ss_o      = 1'b1;
    assign dac_spi_sck_o         = 1'b0;
    assign dac_spi_mosi_o        = 1'b0;
    assign dac_eeprom_iic_scl_o  = 1'b1;
    assign dac_eeprom_iic_sda_io = 1'bz;

endmodule

// File: tb/tb_dclock_wrapper.sv
// Bench for dclock_wrapper: UART frames in, echoed frames decoded from TX and
// checked against a frame-level reference model; LEDs and DAC pins checked
// against the same model.
`timescale 1ns/1ps
module tb_dclock_wrapper;

    localparam int CLK_FREQ = 921_600;
    localparam int BAUD     = 57600;
    localparam int HB_DIV   = 1000;
    localparam int BIT      = CLK_FREQ / BAUD;   // 16 clocks per bit

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clk_n;
    logic rst;
    logic rxd;
    always #2.5 clk = ~clk;
    assign clk_n = ~clk;

    logic        txd, led1, led2, led3, led4, pan1, pan2;
    logic        dci12_p, dci12_n, dci34_p, dci34_n;
    logic [13:0] d12_p, d12_n, d34_p, d34_n;
    logic        ss12, ss34, ssclk, sck, mosi, scl;
    wire         sda;

    dclock_wrapper #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HB_DIV(HB_DIV)) dut (
        .sys_clk_p(clk), .sys_clk_n(clk_n), .rst(rst),
        .uart_rxd_i(rxd), .uart_txd_o(txd),
        .led_1_o(led1), .led_2_o(led2), .led_3_o(led3), .led_4_o(led4),
        .panel_led_1_o(pan1), .panel_led_2_o(pan2),
        .dac_1_2_dci_p_ddr_o(dci12_p), .dac_1_2_dci_n_ddr_o(dci12_n),
        .dac_3_4_dci_p_ddr_o(dci34_p), .dac_3_4_dci_n_ddr_o(dci34_n),
        .dac_1_2_data_p_ddr_o(d12_p), .dac_1_2_data_n_ddr_o(d12_n),
        .dac_3_4_data_p_ddr_o(d34_p), .dac_3_4_data_n_ddr_o(d34_n),
        .dac_1_2_dco_p_i(1'b0), .dac_1_2_dco_n_i(1'b1),
        .dac_3_4_dco_p_i(1'b0), .dac_3_4_dco_n_i(1'b1),
        .dac_1_2_spi_ss_o(ss12), .dac_3_4_spi_ss_o(ss34), .dac_clk_spi_ss_o(ssclk),
        .dac_spi_sck_o(sck), .dac_spi_mosi_o(mosi), .dac_spi_miso_i(1'b0),
        .dac_eeprom_iic_scl_o(scl), .dac_eeprom_iic_sda_io(sda)
    );

    // Non-reset clock edges seen, for the heartbeat expectation.
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];   // {stop, parity, data} of each expected echo
    logic [9:0] got_q[$];

    // Reference model state at frame level.
    logic [7:0] m_byte;
    logic       m_led2, m_perr, m_ferr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A frame is accepted only with even parity and a high stop bit.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic stop_ok);
        if (((^d) == p) && stop_ok) begin
            m_byte = d;
            m_led2 = ~m_led2;
            m_perr = 1'b0;
            m_ferr = 1'b0;
            exp_q.push_back({1'b1, p, d});
        end else begin
            if ((^d) != p) m_perr = 1'b1;
            if (!stop_ok)  m_ferr = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_ok);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        chk("rx_busy_in_frame", pan1, 1);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = p;
        repeat (BIT) @(negedge clk);
        if (stop_ok) begin
            rxd = 1'b1;
            repeat (BIT) @(negedge clk);
        end else begin
            rxd = 1'b0;
            repeat (2 * BIT) @(negedge clk);
            rxd = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        model_frame(d, p, stop_ok);
    endtask

    task automatic chk_state(input logic with_led2);
        repeat (4) @(negedge clk);
        chk("dac12_p", d12_p, {m_byte, 6'b0});
        chk("dac12_n", d12_n, 14'(~{m_byte, 6'b0}));
        chk("dac34_p", d34_p, {m_byte, 6'b0});
        chk("dac34_n", d34_n, 14'(~{m_byte, 6'b0}));
        if (with_led2) chk("led2_toggle", led2, m_led2);
        chk("led3_parity", led3, m_perr);
        chk("led4_framing", led4, m_ferr);
    endtask

    task automatic chk_hb();
        chk("led1_heartbeat", led1, (cyc / HB_DIV) % 2);
    endtask

    // Wait (bounded) for the expected echoes, then compare them in order.
    task automatic wait_echo();
        int n;
        int lim;
        n = exp_q.size();
        lim = 13 * BIT * (n + 1);
        for (int t = 0; t < lim; t++) begin
            if (n > 0 && got_q.size() >= n) break;
            @(negedge clk);
        end
        chk("echo_count", got_q.size(), n);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk("echo_frame", g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- TX line monitor ----------------
    initial begin
        logic [7:0] b;
        logic p;
        logic s;
        wait (rst === 1'b0);
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                p = txd;
                repeat (BIT) @(negedge clk);
                s = txd;
                got_q.push_back({s, p, b});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        logic [7:0] msg [3];
        msg[0] = 8'h31; msg[1] = 8'h39; msg[2] = 8'h32;
        m_byte = 8'h00; m_led2 = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;

        rst = 1'b1;
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_led1", led1, 0);
        chk("rst_pan1", pan1, 0);
        chk("rst_pan2", pan2, 0);
        chk("rst_ss", {ss12, ss34, ssclk}, 3'b111);
        chk("rst_sck_mosi_scl", {sck, mosi, scl}, 3'b001);
        chk("dci_levels", {dci12_p, dci12_n, dci34_p, dci34_n}, 4'b0101);
        chk_state(1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_hb();

        // 'h' then 'i' with correct parity
        send_frame(8'h68, 1'b1, 1'b1);
        chk_state(1'b1);
        chk("tx_busy_echo", pan2, 1);
        send_frame(8'h69, 1'b0, 1'b1);
        chk_state(1'b1);
        wait_echo();
        chk("rx_idle", pan1, 0);

        // back-to-back frames, no gap
        for (int i = 0; i < 3; i++) send_frame(msg[i], ^msg[i], 1'b1);
        chk_state(1'b1);
        wait_echo();
        chk_hb();

        // parity error
        send_frame(8'h0F, 1'b1, 1'b1);
        chk_state(1'b1);
        wait_echo();

        // framing errors; parity flag must persist
        send_frame(8'h33, ^8'h33, 1'b0);
        chk_state(1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b0);
        chk_state(1'b1);
        wait_echo();
        d = 8'($urandom_range(0, 255));
        send_frame(d, ^d, 1'b1);
        chk_state(1'b1);
        wait_echo();

        // start-bit glitch shorter than half a bit
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_rx_idle", pan1, 0);
        chk_state(1'b1);
        wait_echo();
        chk_hb();

        // random frames with occasional parity/framing errors
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom_range(0, 255));
            perr = ($urandom_range(0, 3) == 0);
            ferr = ($urandom_range(0, 5) == 0);
            send_frame(d, (^d) ^ perr, !ferr);
            chk_state(1'b1);
        end
        wait_echo();
        chk_hb();

        // line noise, then recovery
        for (int i = 0; i < 200; i++) begin
            rxd = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
            rxd = 1'b1;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        repeat (11 * BIT + 4) @(negedge clk);
        chk("noise_rx_idle", pan1, 0);
        repeat (24 * BIT) @(negedge clk);
        chk("noise_tx_idle", pan2, 0);
        exp_q.delete();
        got_q.delete();
        send_frame(8'h68, 1'b1, 1'b1);
        chk_state(1'b0);
        wait_echo();
        chk_hb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
